seq_check_mc: RTL

SEQ_CHECK_MC -- requirements
Module: seq_check_mc

---
 rtl/seq_check_mc.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seq_check_mc.sv
// Multi-channel sequence checker for a |=> b[*MIN_REP:MAX_REP] ##DLY c.
// Each channel runs its own FSM; pulses, sticky flags and shared counters are registered.
module seq_check_mc #(
  parameter int NCH     = 4,
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 5,
  parameter int DLY     = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     en_i,
  input  logic               clr_i,
  input  logic [NCH-1:0]     a_i,
  input  logic [NCH-1:0]     b_i,
  input  logic [NCH-1:0]     c_i,
  output logic [NCH-1:0]     pass_o,
  output logic [NCH-1:0]     fail_o,
  output logic [2*NCH-1:0]   fail_code_o,
  output logic [NCH-1:0]     fail_sticky_o,
  output logic [NCH-1:0]     busy_o,
  output logic [CNT_W-1:0]   pass_cnt_o,
  output logic [CNT_W-1:0]   fail_cnt_o,
  output logic [CNT_W-1:0]   ovl_cnt_o
);

  localparam int LW = $clog2(MAX_REP + 1);
  localparam int DW = $clog2(DLY + 1);
  localparam logic [1:0] CODE_SHORT = 2'b01;
  localparam logic [1:0] CODE_NO_C  = 2'b10;

  typedef enum logic [1:0] {IDLE, REP, WAIT} state_t;

  logic [NCH-1:0]   pass_ev;
  logic [NCH-1:0]   fail_ev;
  logic [NCH-1:0]   ovl_ev;
  logic [2*NCH-1:0] code_ev;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [NCH-1:0] ev);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'($countones(ev));
    if (sum[CNT_W]) sat_add = {CNT_W{1'b1}};
    else            sat_add = sum[CNT_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [LW-1:0] len_reg, len_next;
      logic [DW-1:0] dcnt_reg, dcnt_next;
      logic          pass_next, fail_next, ovl_next;
      logic [1:0]    code_next;

      always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        dcnt_next  = dcnt_reg;
        pass_next  = 1'b0;
        fail_next  = 1'b0;
        ovl_next   = 1'b0;
        code_next  = 2'b00;
        case (state_reg)
          IDLE: begin
            if (a_i[gi]) begin
              state_next = REP;
              len_next   = '0;
            end
          end
          REP: begin
            ovl_next = a_i[gi];
            if (b_i[gi]) begin
              if (len_reg == LW'(MAX_REP - 1)) begin
                state_next = WAIT;
                dcnt_next  = '0;
              end else begin
                len_next = len_reg + 1'b1;
              end
            end else if (len_reg < LW'(MIN_REP)) begin
              fail_next  = 1'b1;
              code_next  = CODE_SHORT;
              state_next = IDLE;
            end else if (DLY == 1) begin
              // This edge is already DLY past the last b-high edge.
              pass_next  = c_i[gi];
              fail_next  = ~c_i[gi];
              code_next  = c_i[gi] ? 2'b00 : CODE_NO_C;
              state_next = IDLE;
            end else begin
              state_next = WAIT;
              dcnt_next  = DW'(1);
            end
          end
          WAIT: begin
            ovl_next = a_i[gi];
            if (dcnt_reg == DW'(DLY - 1)) begin
              pass_next  = c_i[gi];
              fail_next  = ~c_i[gi];
              code_next  = c_i[gi] ? 2'b00 : CODE_NO_C;
              state_next = IDLE;
            end else begin
              dcnt_next = dcnt_reg + 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
        if (!en_i[gi]) begin
          state_next = IDLE;
          pass_next  = 1'b0;
          fail_next  = 1'b0;
          ovl_next   = 1'b0;
          code_next  = 2'b00;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg <= IDLE;
          len_reg   <= '0;
          dcnt_reg  <= '0;
        end else begin
          state_reg <= state_next;
          len_reg   <= len_next;
          dcnt_reg  <= dcnt_next;
        end
      end

      assign pass_ev[gi]        = pass_next;
      assign fail_ev[gi]        = fail_next;
      assign ovl_ev[gi]         = ovl_next;
      assign code_ev[2*gi +: 2] = code_next;
      assign busy_o[gi]         = (state_reg != IDLE);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_o        <= '0;
      fail_o        <= '0;
      fail_code_o   <= '0;
      fail_sticky_o <= '0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
      ovl_cnt_o     <= '0;
    end else begin
      pass_o      <= pass_ev;
      fail_o      <= fail_ev;
      fail_code_o <= code_ev;
      if (clr_i) begin
        fail_sticky_o <= '0;
        pass_cnt_o    <= '0;
        fail_cnt_o    <= '0;
        ovl_cnt_o     <= '0;
      end else begin
        fail_sticky_o <= fail_sticky_o | fail_ev;
        pass_cnt_o    <= sat_add(pass_cnt_o, pass_ev);
        fail_cnt_o    <= sat_add(fail_cnt_o, fail_ev);
        ovl_cnt_o     <= sat_add(ovl_cnt_o, ovl_ev);
      end
    end
  end

endmodule
